// File: rtl/stopwatch_bcd_scan_if.sv
// Control and display bundle for stopwatch_bcd_scan: divided-clock level and
// control pulses in, BCD count, status and multiplexed 7-segment drive out.
interface stopwatch_bcd_scan_if;
    logic        clk_slow;
    logic        start;
    logic        stop;
    logic        clear;
    logic [15:0] bcd;
    logic        running;
    logic        ovf;
    logic [3:0]  an;
    logic [6:0]  seg;

    modport master (
        output clk_slow, start, stop, clear,
        input  bcd, running, ovf, an, seg
    );

    modport slave (
        input  clk_slow, start, stop, clear,
        output bcd, running, ovf, an, seg
    );
endinterface

// File: rtl/stopwatch_bcd_scan.sv
// 4-digit BCD stopwatch counting rising edges of a divided-clock level, with a
// time-multiplexed 7-segment display. Define LZ_BLANK_EN to blank leading zeros.
module stopwatch_bcd_scan #(
    parameter logic [15:0] SCAN_DIV = 16'd50000
) (
    input  logic                clk,
    input  logic                reset,
    stopwatch_bcd_scan_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t      state;
    state_t      state_next;
    logic        slow_d;
    logic        tick;
    logic [15:0] bcd_r;
    logic [15:0] bcd_inc;
    logic        inc_carry;
    logic        running_r;
    logic        ovf_r;
    logic [15:0] scan_cnt;
    logic        scan_tc;
    logic [1:0]  digit_idx;
    logic [1:0]  idx_next;
    logic [3:0]  digit_val;
    logic        digit_blank;
    logic        blank_next;
    logic [3:0]  an_r;
    logic [6:0]  seg_r;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    // One tick per rising edge of the divided clock, however long it stays high.
    assign tick = bus.clk_slow & ~slow_d;

    always_comb begin
        // NOTE: default first so no path through this block can infer a latch.
        state_next = state;
        if (bus.clear) begin
            state_next = IDLE;
        end else if (bus.start) begin
            state_next = RUN;
        end else if (bus.stop && state == RUN) begin
            state_next = PAUSE;
        end
    end

    // Per-digit ripple: a 9 with carry-in rolls to 0 and passes the carry up.
    always_comb begin
        bcd_inc   = bcd_r;
        inc_carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (inc_carry) begin
                if (bcd_r[4*i +: 4] == 4'd9) begin
                    bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*i +: 4] = bcd_r[4*i +: 4] + 4'd1;
                    inc_carry         = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples the pre-edge values.
        if (reset) begin
            state     <= IDLE;
            running_r <= 1'b0;
            bcd_r     <= 16'h0000;
            ovf_r     <= 1'b0;
            slow_d    <= 1'b0;
        end else begin
            slow_d    <= bus.clk_slow;
            state     <= state_next;
            running_r <= (state_next == RUN);
            if (bus.clear) begin
                bcd_r <= 16'h0000;
                ovf_r <= 1'b0;
            end else if (state == RUN && tick) begin
                bcd_r <= bcd_inc;
                if (inc_carry) begin
                    ovf_r <= 1'b1;
                end
            end
        end
    end

    assign scan_tc  = (scan_cnt == SCAN_DIV - 16'd1);
    assign idx_next = digit_idx + 2'd1;

    always_comb begin
        blank_next = 1'b0;
`ifdef LZ_BLANK_EN
        case (idx_next)
            2'd3:    blank_next = (bcd_r[15:12] == 4'd0);
            2'd2:    blank_next = (bcd_r[15:8] == 8'd0);
            2'd1:    blank_next = (bcd_r[15:4] == 12'd0);
            default: blank_next = 1'b0;
        endcase
`endif
    end

    // Digit data is captured with the index; an/seg follow one cycle later together.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt    <= 16'd0;
            digit_idx   <= 2'd0;
            digit_val   <= 4'd0;
            digit_blank <= 1'b0;
            an_r        <= 4'b1110;
            seg_r       <= 7'b1000000;
        end else begin
            if (scan_tc) begin
                scan_cnt    <= 16'd0;
                digit_idx   <= idx_next;
                digit_val   <= bcd_r[{idx_next, 2'b00} +: 4];
                digit_blank <= blank_next;
            end else begin
                scan_cnt <= scan_cnt + 16'd1;
            end
            an_r  <= ~(4'b0001 << digit_idx);
            seg_r <= digit_blank ? 7'b1111111 : seg_decode(digit_val);
        end
    end

    assign bus.bcd     = bcd_r;
    assign bus.running = running_r;
    assign bus.ovf     = ovf_r;
    assign bus.an      = an_r;
    assign bus.seg     = seg_r;
endmodule

// File: tb/tb_stopwatch_bcd_scan.sv
// Self-checking bench for stopwatch_bcd_scan: a behavioural model queues every
// expected bcd change; scenario tasks check status and the display scan inline.
module tb_stopwatch_bcd_scan;
    typedef enum {M_IDLE, M_RUN, M_PAUSE} m_state_t;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    logic [15:0] exp_q[$];
    logic [15:0] prev_bcd;
    int          m_cnt;
    logic        m_ovf;
    m_state_t    m_state;
    logic        m_slow_d;

    stopwatch_bcd_scan_if bus ();

    stopwatch_bcd_scan #(
        .SCAN_DIV(16'd4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        to_bcd = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Scoreboard: every bcd change must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset) begin
            prev_bcd = bus.bcd;
        end else if (bus.bcd !== prev_bcd) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL bcd_stream: got %h with no change expected", bus.bcd);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (bus.bcd !== e) begin
                    miscompares++;
                    $display("FAIL bcd_stream: got %h expected %h", bus.bcd, e);
                end
            end
            prev_bcd = bus.bcd;
        end
    end

    // Applies one clk cycle of inputs starting at a negedge and updates the model.
    task automatic drive_cycle(input logic s, input logic p, input logic c, input logic slow);
        logic tk;
        tk           = slow & ~m_slow_d;
        bus.start    = s;
        bus.stop     = p;
        bus.clear    = c;
        bus.clk_slow = slow;
        if (c) begin
            if (m_cnt != 0) exp_q.push_back(16'h0000);
            m_cnt   = 0;
            m_ovf   = 1'b0;
            m_state = M_IDLE;
        end else begin
            if (m_state == M_RUN && tk) begin
                m_cnt = (m_cnt + 1) % 10000;
                if (m_cnt == 0) m_ovf = 1'b1;
                exp_q.push_back(to_bcd(m_cnt));
            end
            if (s) m_state = M_RUN;
            else if (p && m_state == M_RUN) m_state = M_PAUSE;
        end
        m_slow_d = slow;
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.clear = 1'b0;
    endtask

    task automatic run_ticks(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            repeat (hi) drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
            repeat (lo) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Waits (bounded) for the an rotation to re-enter the units slot.
    task automatic sync_to_units(output bit ok);
        logic [3:0] prev_an;
        int         waited;
        waited  = 0;
        prev_an = bus.an;
        @(negedge clk);
        while (!(prev_an == 4'b0111 && bus.an == 4'b1110) && waited < 40) begin
            prev_an = bus.an;
            @(negedge clk);
            waited++;
        end
        ok = (waited < 40);
    endtask

    task automatic test_reset;
        reset        = 1'b1;
        bus.clk_slow = 1'b0;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.clear    = 1'b0;
        m_cnt        = 0;
        m_ovf        = 1'b0;
        m_state      = M_IDLE;
        m_slow_d     = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.bcd !== 16'h0000) begin
            miscompares++; $display("FAIL reset_bcd: got %h expected 0000", bus.bcd);
        end
        vectors++;
        if (bus.running !== 1'b0 || bus.ovf !== 1'b0) begin
            miscompares++; $display("FAIL reset_flags: running=%b ovf=%b expected 0 0", bus.running, bus.ovf);
        end
        vectors++;
        if (bus.an !== 4'b1110) begin
            miscompares++; $display("FAIL reset_an: got %b expected 1110", bus.an);
        end
        vectors++;
        if (bus.seg !== 7'b1000000) begin
            miscompares++; $display("FAIL reset_seg: got %b expected 1000000", bus.seg);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_count_pause;
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (bus.running !== 1'b1) begin
            miscompares++; $display("FAIL start_running: got %b expected 1", bus.running);
        end
        run_ticks(12, 5, 5);
        vectors++;
        if (bus.bcd !== 16'h0012) begin
            miscompares++; $display("FAIL count12: got %h expected 0012", bus.bcd);
        end
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        run_ticks(5, 5, 5);
        vectors++;
        if (bus.bcd !== 16'h0012 || bus.running !== 1'b0) begin
            miscompares++; $display("FAIL paused: bcd=%h running=%b expected 0012 0", bus.bcd, bus.running);
        end
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        run_ticks(1, 5, 5);
        vectors++;
        if (bus.bcd !== 16'h0013 || bus.running !== 1'b1) begin
            miscompares++; $display("FAIL resume: bcd=%h running=%b expected 0013 1", bus.bcd, bus.running);
        end
    endtask

    task automatic test_long_level;
        repeat (20) drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (bus.bcd !== 16'h0014) begin
            miscompares++; $display("FAIL long_level: got %h expected 0014", bus.bcd);
        end
    endtask

    task automatic test_wrap;
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        run_ticks(9998, 1, 1);
        vectors++;
        if (bus.bcd !== 16'h9998 || bus.ovf !== 1'b0) begin
            miscompares++; $display("FAIL preload: bcd=%h ovf=%b expected 9998 0", bus.bcd, bus.ovf);
        end
        run_ticks(1, 1, 1);
        vectors++;
        if (bus.bcd !== 16'h9999 || bus.ovf !== 1'b0) begin
            miscompares++; $display("FAIL at9999: bcd=%h ovf=%b expected 9999 0", bus.bcd, bus.ovf);
        end
        run_ticks(1, 1, 1);
        vectors++;
        if (bus.bcd !== 16'h0000 || bus.ovf !== 1'b1) begin
            miscompares++; $display("FAIL wrap: bcd=%h ovf=%b expected 0000 1", bus.bcd, bus.ovf);
        end
        run_ticks(1, 1, 1);
        vectors++;
        if (bus.bcd !== 16'h0001 || bus.ovf !== 1'b1 || bus.running !== 1'b1) begin
            miscompares++;
            $display("FAIL after_wrap: bcd=%h ovf=%b running=%b expected 0001 1 1", bus.bcd, bus.ovf, bus.running);
        end
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        vectors++;
        if (bus.bcd !== 16'h0000 || bus.ovf !== 1'b0 || bus.running !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_clear: bcd=%h ovf=%b running=%b expected 0000 0 0", bus.bcd, bus.ovf, bus.running);
        end
    endtask

    task automatic test_simultaneous;
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        run_ticks(3, 1, 1);
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b1);
        vectors++;
        if (bus.bcd !== 16'h0000 || bus.running !== 1'b0) begin
            miscompares++; $display("FAIL clear_tick: bcd=%h running=%b expected 0000 0", bus.bcd, bus.running);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        run_ticks(2, 1, 1);
        vectors++;
        if (bus.bcd !== 16'h0000) begin
            miscompares++; $display("FAIL idle_no_count: got %h expected 0000", bus.bcd);
        end
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        run_ticks(2, 1, 1);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b1);
        vectors++;
        if (bus.bcd !== 16'h0003 || bus.running !== 1'b0) begin
            miscompares++; $display("FAIL stop_tick: bcd=%h running=%b expected 0003 0", bus.bcd, bus.running);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        run_ticks(2, 1, 1);
        vectors++;
        if (bus.bcd !== 16'h0003) begin
            miscompares++; $display("FAIL pause_hold: got %h expected 0003", bus.bcd);
        end
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (bus.bcd !== 16'h0003 || bus.running !== 1'b1) begin
            miscompares++; $display("FAIL start_tick: bcd=%h running=%b expected 0003 1", bus.bcd, bus.running);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        run_ticks(1, 1, 1);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b1, 1'b0);
        vectors++;
        if (bus.bcd !== 16'h0000 || bus.running !== 1'b0) begin
            miscompares++; $display("FAIL start_clear: bcd=%h running=%b expected 0000 0", bus.bcd, bus.running);
        end
        run_ticks(2, 1, 1);
        vectors++;
        if (bus.bcd !== 16'h0000 || bus.running !== 1'b0) begin
            miscompares++; $display("FAIL start_clear_idle: bcd=%h running=%b expected 0000 0", bus.bcd, bus.running);
        end
    endtask

    task automatic test_scan;
        bit          ok;
        logic [27:0] segs;
        segs = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        run_ticks(1234, 1, 1);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (20) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        sync_to_units(ok);
        vectors++;
        if (!ok) begin
            miscompares++; $display("FAIL scan_sync: an=%b never wrapped to 1110", bus.an);
        end else begin
            for (int k = 0; k < 4; k++) begin
                for (int c = 0; c < 4; c++) begin
                    logic [3:0] ea;
                    ea = ~(4'b0001 << k);
                    vectors++;
                    if (bus.an !== ea || bus.seg !== segs[7*k +: 7]) begin
                        miscompares++;
                        $display("FAIL scan_1234 slot%0d cyc%0d: an=%b seg=%b expected %b %b",
                                 k, c, bus.an, bus.seg, ea, segs[7*k +: 7]);
                    end
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic test_lz_blank;
        bit          ok;
        logic [6:0]  lead;
        logic [27:0] segs;
`ifdef LZ_BLANK_EN
        lead = 7'b1111111;
`else
        lead = 7'b1000000;
`endif
        segs = {lead, lead, lead, 7'b1111000};
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        run_ticks(7, 1, 1);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (20) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        sync_to_units(ok);
        vectors++;
        if (!ok) begin
            miscompares++; $display("FAIL lz_sync: an=%b never wrapped to 1110", bus.an);
        end else begin
            for (int k = 0; k < 4; k++) begin
                logic [3:0] ea;
                ea = ~(4'b0001 << k);
                vectors++;
                if (bus.an !== ea || bus.seg !== segs[7*k +: 7]) begin
                    miscompares++;
                    $display("FAIL scan_0007 slot%0d: an=%b seg=%b expected %b %b",
                             k, bus.an, bus.seg, ea, segs[7*k +: 7]);
                end
                repeat (4) @(negedge clk);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_count_pause();
        test_long_level();
        test_wrap();
        test_simultaneous();
        test_scan();
        test_lz_blank();
        repeat (2) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++; $display("FAIL bcd_stream_drain: %0d expected changes never seen, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
